// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
//   - default address/data widths
//   - FSM state encoding (2-bit)
//   - wait-counter width helper (safe for a disabled timeout of 0)
package bus_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // $clog2(TIMEOUT+1) collapses to 0 bits when TIMEOUT is 0; keep at least one.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bus_timeout.sv
// Saturating bus wait counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the counter (held while the arbiter is idle)
//   en         : count one bus wait cycle
//   expired    : counter has reached TIMEOUT (never asserts when TIMEOUT is 0)
module bus_timeout
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int             CW    = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    // Stops at LIMIT instead of wrapping so a long stall cannot re-arm the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, one-slave memory bus arbiter (instruction fetch + data port).
// Serialises transactions, breaks ties round-robin, aborts on timeout.
//   i_clk, i_rstn              : clock, asynchronous active-low reset
//   i_i_* / o_i_*              : fetch port (req, addr -> rdata, ack, err)
//   i_d_* / o_d_*              : data port (req, we, addr, wdata, be -> rdata, ack, err)
//   o_bus_* / i_bus_rdata/ack  : single slave bus
// All outputs come straight from registers.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_i_req,
    input  logic [ADDR_W-1:0]     i_i_addr,
    output logic [DATA_W-1:0]     o_i_rdata,
    output logic                  o_i_ack,
    output logic                  o_i_err,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [ADDR_W-1:0]     i_d_addr,
    input  logic [DATA_W-1:0]     i_d_wdata,
    input  logic [DATA_W/8-1:0]   i_d_be,
    output logic [DATA_W-1:0]     o_d_rdata,
    output logic                  o_d_ack,
    output logic                  o_d_err,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [ADDR_W-1:0]     o_bus_addr,
    output logic [DATA_W-1:0]     o_bus_wdata,
    output logic [DATA_W/8-1:0]   o_bus_be,
    input  logic [DATA_W-1:0]     i_bus_rdata,
    input  logic                  i_bus_ack
);

    state_t            state;
    logic              last_d;   // 1: the most recent grant went to the data port
    logic [DATA_W-1:0] rdata_q;
    logic              expired;
    logic              busy;

    assign busy = (state == ST_BUSY_I) || (state == ST_BUSY_D);

    bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (i_clk),
        .rst_n   (i_rstn),
        .clr     (state == ST_IDLE),
        .en      (busy),
        .expired (expired)
    );

    // Both ports read the same register; only read completions update it.
    assign o_i_rdata = rdata_q;
    assign o_d_rdata = rdata_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= ST_IDLE;
            last_d      <= 1'b0;
            rdata_q     <= '0;
            o_i_ack     <= 1'b0;
            o_i_err     <= 1'b0;
            o_d_ack     <= 1'b0;
            o_d_err     <= 1'b0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_bus_be    <= '0;
        end else begin
            o_i_ack <= 1'b0;
            o_i_err <= 1'b0;
            o_d_ack <= 1'b0;
            o_d_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Data wins when alone, or on a tie when fetch went last.
                    if (i_d_req && (!i_i_req || !last_d)) begin
                        state       <= ST_BUSY_D;
                        last_d      <= 1'b1;
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= i_d_we;
                        o_bus_addr  <= i_d_addr;
                        o_bus_wdata <= i_d_wdata;
                        o_bus_be    <= i_d_be;
                    end else if (i_i_req) begin
                        state       <= ST_BUSY_I;
                        last_d      <= 1'b0;
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= 1'b0;
                        o_bus_addr  <= i_i_addr;
                        o_bus_wdata <= '0;
                        o_bus_be    <= '1;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    // An ack in the expiring cycle still counts as a completion.
                    if (i_bus_ack) begin
                        state     <= ST_DONE;
                        o_bus_req <= 1'b0;
                        if (!o_bus_we) rdata_q <= i_bus_rdata;
                        if (state == ST_BUSY_I) o_i_ack <= 1'b1;
                        else                    o_d_ack <= 1'b1;
                    end else if (expired) begin
                        state     <= ST_DONE;
                        o_bus_req <= 1'b0;
                        if (state == ST_BUSY_I) o_i_err <= 1'b1;
                        else                    o_d_err <= 1'b1;
                    end
                end
                // Completion pulse is on the outputs this cycle; requests are
                // not looked at until IDLE.
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave memory arbiter that shares the core's single external memory bus between the instruction-fetch port and the data port (loads, stores, LR/SC). It sits between the pipeline's fetch/memory stages and the bus. It serialises transactions, breaks ties round-robin, and aborts transactions that exceed a timeout so the core can raise an access-fault exception.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; the byte-enable width is `DATA_W/8`.
- `TIMEOUT`, default 255: maximum bus wait cycles before abort. A value of 0 disables the timeout.

Ports (name, direction, width, meaning):
- `i_clk`, in, 1: clock.
- `i_rstn`, in, 1: reset. Asynchronous, active-low.
- `i_i_req`, in, 1: instruction fetch request. Level signal; held until ack or err.
- `i_i_addr`, in, `ADDR_W`: fetch address.
- `o_i_rdata`, out, `DATA_W`: fetched word. Valid when `o_i_ack` is high.
- `o_i_ack`, out, 1: one-cycle fetch completion pulse.
- `o_i_err`, out, 1: one-cycle fetch timeout pulse.
- `i_d_req`, in, 1: data request. Level signal; held until ack or err.
- `i_d_we`, in, 1: 1 = write, 0 = read.
- `i_d_addr`, in, `ADDR_W`: data address.
- `i_d_wdata`, in, `DATA_W`: store data.
- `i_d_be`, in, `DATA_W/8`: byte enables.
- `o_d_rdata`, out, `DATA_W`: load data. Valid when `o_d_ack` is high.
- `o_d_ack`, out, 1: one-cycle data completion pulse.
- `o_d_err`, out, 1: one-cycle data timeout pulse.
- `o_bus_req`, out, 1: bus request. Held until `i_bus_ack` or abort.
- `o_bus_we`, out, 1: bus write enable.
- `o_bus_addr`, out, `ADDR_W`: bus address.
- `o_bus_wdata`, out, `DATA_W`: bus write data.
- `o_bus_be`, out, `DATA_W/8`: bus byte enables.
- `i_bus_rdata`, in, `DATA_W`: bus read data. Valid with `i_bus_ack`.
- `i_bus_ack`, in, 1: one-cycle slave completion.

## Operation
- **States:** IDLE, BUSY_I, BUSY_D, DONE.
- **IDLE:**
  - Only `i_i_req` high: go to BUSY_I.
  - Only `i_d_req` high: go to BUSY_D.
  - Both high: grant the port not granted last (`last_d` flag), then update `last_d`.
  - On grant, latch the winner's addr, we, wdata and be into bus registers. The instruction port always latches we=0 and be=all-ones.
- **BUSY_x:**
  - `o_bus_req`=1 and the bus registers are stable.
  - On `i_bus_ack`: register `i_bus_rdata`, set `err`=0, go to DONE.
  - When the wait counter reaches `TIMEOUT` without an ack: set `err`=1, drop `o_bus_req`, go to DONE.
- **DONE:**
  - Pulse `o_x_ack` (when `err`=0) or `o_x_err` (when `err`=1) to the granted port for exactly one cycle. `o_x_rdata` holds the registered data.
  - Go to IDLE next cycle.
- **Requests ignored in DONE:** a requester still holding req in DONE is not re-granted that cycle. It must drop req, or present a new request, after sampling ack/err.
- **Wait counter:** cleared on grant, increments each BUSY cycle, width `$clog2(TIMEOUT+1)`, saturates and never wraps. With `TIMEOUT`=0 it is disabled and the transaction waits indefinitely.
- **Stray ack:** an `i_bus_ack` arriving in IDLE or DONE (late ack after abort) is ignored.
- **Request dropped mid-transaction** (pipeline flush): the bus transaction still completes from the latched copy, and ack/err is still pulsed. The requester discards it.
- **rdata outputs:** `o_i_rdata` and `o_d_rdata` are the same register, fanned out. A write completion leaves it unchanged.

## Timing
- **Reset:** all outputs 0, state IDLE, `last_d`=0 (the first tie goes to data), counter 0, data register 0. Reset asserted mid-transaction drops `o_bus_req` immediately (asynchronous); no ack/err is issued.
- **Latency:** request seen in IDLE at cycle 0 → `o_bus_req` high at cycle 1. `i_bus_ack` at cycle k → `o_x_ack` at cycle k+1 → IDLE at cycle k+2.
  - Minimum with a zero-wait slave (ack in cycle 1): ack at cycle 2, next grant at cycle 3.
- **Timeout:** `o_x_err` occurs `TIMEOUT`+1 cycles after `o_bus_req` rises, when no ack arrives.
- **Registered outputs:** all outputs are registered; no combinational path from any input to any output.

## Structure
- State encoding (2-bit) and default `ADDR_W`/`DATA_W` go in `arvi_defines.vh` alongside the existing width defines.
- One sub-module, `bus_timeout`: the saturating wait counter with clear/enable inputs and an expired output, parameterised by `TIMEOUT`.
- The FSM, round-robin flag and bus registers stay in `bus_arbiter`.

## Test plan
- **Fetch alone:** `i_i_req`, addr 0x100; slave acks in cycle 1 with 0x00000013 → `o_bus_req` at cycle 1, `o_i_ack` pulse at cycle 2 with `o_i_rdata`=0x00000013, `o_d_ack` stays 0.
- **Tie after reset:** both requests at cycle 0 → data granted first (`o_bus_we`/`o_bus_be` follow the data port). With both requests held, the next grant goes to fetch, then data, alternating.
- **Store:** `i_d_we`=1, addr 0x2000, wdata 0xDEADBEEF, be 4'b0011; ack after 5 wait cycles → bus fields match for all 6 BUSY cycles, `o_d_ack` at cycle 7, `o_d_rdata` unchanged.
- **Timeout:** `TIMEOUT`=4, no ack → `o_d_err` pulse at cycle 6, `o_bus_req` low from cycle 6. A late ack at cycle 8 causes no ack pulse.
- **Reset mid-transaction:** `i_rstn` low during BUSY_I → `o_bus_req` drops the same cycle, no ack/err. After release, a fetch request is granted normally.
- **Flush:** `i_d_req` dropped one cycle after grant → transaction completes on the bus, `o_d_ack` still pulses once, no re-grant.
